// File: rtl/imem_loader.sv
// Byte-stream boot loader: assembles little-endian words and writes them to instruction memory.
// Best case 4 cycles per header and 5 cycles per word; rx_ready drops during writes and outside a load.
module imem_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [31:0] MAX_WORDS = 32'h0800_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        MemWrite,
    output logic [31:0] WAddr,
    output logic [31:0] WData,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        core_hold
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_DATA,
        S_WR,
        S_DONE,
        S_ERR
    } state_t;

    state_t      r_state;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_shift;
    logic [31:0] r_len;
    logic [31:0] r_word_idx;
    logic        r_rx_ready;
    logic        r_memwrite;
    logic [31:0] r_waddr;
    logic [31:0] r_wdata;
    logic        r_busy;
    logic        r_done;
    logic        r_error;
    logic        r_core_hold;

    logic        w_xfer;
    logic        w_last_byte;
    logic [31:0] w_shift_next;
    logic        w_len_bad;

    assign w_xfer       = rx_valid & r_rx_ready;
    assign w_last_byte  = (r_byte_cnt == 2'd3);
    // Shifting in from the top leaves the first byte of four in bits [7:0].
    assign w_shift_next = {rx_data, r_shift[31:8]};
    assign w_len_bad    = (w_shift_next == 32'd0) || (w_shift_next > MAX_WORDS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= 2'd0;
            r_shift     <= 32'd0;
            r_len       <= 32'd0;
            r_word_idx  <= 32'd0;
            r_rx_ready  <= 1'b0;
            r_memwrite  <= 1'b0;
            r_waddr     <= 32'd0;
            r_wdata     <= 32'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_core_hold <= 1'b0;
        end else begin
            r_memwrite <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        r_state     <= S_HDR;
                        r_byte_cnt  <= 2'd0;
                        r_rx_ready  <= 1'b1;
                        r_busy      <= 1'b1;
                        r_core_hold <= 1'b1;
                        r_done      <= 1'b0;
                        r_error     <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (w_xfer) begin
                        r_shift    <= w_shift_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_last_byte) begin
                            if (w_len_bad) begin
                                r_state    <= S_ERR;
                                r_rx_ready <= 1'b0;
                                r_busy     <= 1'b0;
                                r_error    <= 1'b1;
                            end else begin
                                r_state    <= S_DATA;
                                r_len      <= w_shift_next;
                                r_word_idx <= 32'd0;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_shift    <= w_shift_next;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (w_last_byte) begin
                            r_state    <= S_WR;
                            r_rx_ready <= 1'b0;
                            r_memwrite <= 1'b1;
                            // Address arithmetic wraps modulo 2^32 by construction.
                            r_waddr    <= BASE_ADDR + (r_word_idx << 2);
                            r_wdata    <= w_shift_next;
                        end
                    end
                end
                S_WR: begin
                    r_word_idx <= r_word_idx + 32'd1;
                    r_byte_cnt <= 2'd0;
                    if (r_word_idx == r_len - 32'd1) begin
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_core_hold <= 1'b0;
                        r_done      <= 1'b1;
                    end else begin
                        r_state    <= S_DATA;
                        r_rx_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_rx_ready  <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_error     <= 1'b0;
                    r_core_hold <= 1'b0;
                end
            endcase
        end
    end

    assign rx_ready  = r_rx_ready;
    assign MemWrite  = r_memwrite;
    assign WAddr     = r_waddr;
    assign WData     = r_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign core_hold = r_core_hold;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; a second instance with a top-of-memory base shares all stimulus.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready, MemWrite, busy, done, error, core_hold;
    logic [31:0] WAddr, WData;
    logic        x_rx_ready, x_MemWrite, x_busy, x_done, x_error, x_core_hold;
    logic [31:0] x_WAddr, x_WData;

    imem_loader u_dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .MemWrite(MemWrite), .WAddr(WAddr), .WData(WData),
        .busy(busy), .done(done), .error(error), .core_hold(core_hold)
    );

    imem_loader #(.BASE_ADDR(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(x_rx_ready), .MemWrite(x_MemWrite), .WAddr(x_WAddr), .WData(x_WData),
        .busy(x_busy), .done(x_done), .error(x_error), .core_hold(x_core_hold)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    logic [31:0] wr_addr [64];
    logic [31:0] wr_data [64];
    logic [31:0] x_addr  [64];
    logic [31:0] x_data  [64];
    int nwr = 0;
    int nx = 0;
    int rdy_bad = 0;

    logic [7:0] s1   [12] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                              8'h93, 8'h05, 8'h20, 8'h00};
    int         gaps [12] = '{2, 0, 5, 1, 0, 3, 0, 4, 0, 1, 2, 5};

    always @(negedge clk) begin
        if (MemWrite) begin
            if (nwr < 64) begin
                wr_addr[nwr[5:0]] = WAddr;
                wr_data[nwr[5:0]] = WData;
            end
            if (rx_ready) rdy_bad++;
            nwr++;
        end
        if (x_MemWrite) begin
            if (nx < 64) begin
                x_addr[nx[5:0]] = x_WAddr;
                x_data[nx[5:0]] = x_WData;
            end
            nx++;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time exceeded, required completion");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered at a negedge; returns at the negedge right after the byte's transfer edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        for (int i = 0; i < gap; i++) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL byte_accept: rx_ready=%b required 1 for byte %h", rx_ready, b);
        end
        @(negedge clk);
    endtask

    task automatic run_stream(input bit use_gaps);
        for (int i = 0; i < 12; i++) send_byte(s1[i], use_gaps ? gaps[i] : 0);
        rx_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_done: done=%b required 1", tag, done);
        end
    endtask

    task automatic check_case1_writes(input string tag, input int base);
        logic [5:0] b;
        b = 6'(base);
        vectors++;
        if (nwr - base !== 2) begin
            errors++;
            $display("FAIL %s_count: writes=%0d required 2", tag, nwr - base);
        end
        vectors++;
        if ({wr_addr[b], wr_data[b]} !== {32'h0, 32'h0010_0513}) begin
            errors++;
            $display("FAIL %s_w0: addr=%h data=%h required 00000000 00100513", tag, wr_addr[b], wr_data[b]);
        end
        vectors++;
        if ({wr_addr[b+6'd1], wr_data[b+6'd1]} !== {32'h4, 32'h0020_0593}) begin
            errors++;
            $display("FAIL %s_w1: addr=%h data=%h required 00000004 00200593", tag,
                     wr_addr[b+6'd1], wr_data[b+6'd1]);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        vectors++;
        if ({rx_ready, MemWrite, busy, done, error, core_hold, WAddr, WData} !== 70'd0) begin
            errors++;
            $display("FAIL reset_outputs: %b%b%b%b%b%b %h %h required all 0",
                     rx_ready, MemWrite, busy, done, error, core_hold, WAddr, WData);
        end
        rst = 1'b1;
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({rx_ready, busy, core_hold, nwr} !== {3'b000, 32'd0}) begin
            errors++;
            $display("FAIL idle_no_accept: rx_ready=%b busy=%b hold=%b writes=%0d required 0 0 0 0",
                     rx_ready, busy, core_hold, nwr);
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_basic();
        int base;
        base = nwr;
        pulse_start();
        vectors++;
        if ({busy, core_hold, rx_ready, done, error} !== 5'b11100) begin
            errors++;
            $display("FAIL basic_hdr: busy/hold/rdy/done/err=%b required 11100",
                     {busy, core_hold, rx_ready, done, error});
        end
        run_stream(1'b0);
        vectors++;
        if ({MemWrite, done, rx_ready} !== 3'b100) begin
            errors++;
            $display("FAIL basic_last_wr: MemWrite/done/rdy=%b required 100", {MemWrite, done, rx_ready});
        end
        @(negedge clk);
        vectors++;
        if ({done, core_hold, busy, error, rx_ready, MemWrite} !== 6'b100000) begin
            errors++;
            $display("FAIL basic_done: done/hold/busy/err/rdy/wr=%b required 100000",
                     {done, core_hold, busy, error, rx_ready, MemWrite});
        end
        check_case1_writes("basic", base);
    endtask

    task automatic test_len_errors();
        int base;
        base = nwr;
        pulse_start();
        for (int i = 0; i < 4; i++) send_byte(8'h00, 0);
        rx_valid = 1'b0;
        vectors++;
        if ({error, core_hold, busy, done, rx_ready} !== 5'b11000) begin
            errors++;
            $display("FAIL len0_err: err/hold/busy/done/rdy=%b required 11000",
                     {error, core_hold, busy, done, rx_ready});
        end
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        rx_valid = 1'b0;
        vectors++;
        if ({error, rx_ready, nwr - base} !== {2'b10, 32'd0}) begin
            errors++;
            $display("FAIL len0_sticky: err=%b rdy=%b writes=%0d required 1 0 0", error, rx_ready, nwr - base);
        end
        pulse_start();
        vectors++;
        if ({error, busy, core_hold, rx_ready} !== 4'b0111) begin
            errors++;
            $display("FAIL err_restart: err/busy/hold/rdy=%b required 0111", {error, busy, core_hold, rx_ready});
        end
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h08, 0);
        rx_valid = 1'b0;
        vectors++;
        if ({error, busy, core_hold} !== 3'b101) begin
            errors++;
            $display("FAIL len_over_max: err/busy/hold=%b required 101", {error, busy, core_hold});
        end
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h08, 0);
        rx_valid = 1'b0;
        vectors++;
        if ({error, busy, rx_ready} !== 3'b011) begin
            errors++;
            $display("FAIL len_eq_max: err/busy/rdy=%b required 011", {error, busy, rx_ready});
        end
        #2 rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_gaps();
        int base, bad0;
        base = nwr;
        bad0 = rdy_bad;
        pulse_start();
        run_stream(1'b1);
        wait_done("gaps");
        check_case1_writes("gaps", base);
        vectors++;
        if (rdy_bad !== bad0) begin
            errors++;
            $display("FAIL gaps_wr_ready: WR cycles with rx_ready=1 is %0d required 0", rdy_bad - bad0);
        end
    endtask

    task automatic test_async_reset();
        int base;
        base = nwr;
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(s1[i], 0);
        rx_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({rx_ready, MemWrite, busy, done, error, core_hold, WAddr, WData} !== 70'd0) begin
            errors++;
            $display("FAIL async_reset: %b%b%b%b%b%b %h %h required all 0",
                     rx_ready, MemWrite, busy, done, error, core_hold, WAddr, WData);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if ({nwr - base, busy} !== {32'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_no_write: writes=%0d busy=%b required 0 0", nwr - base, busy);
        end
        base = nwr;
        pulse_start();
        run_stream(1'b0);
        wait_done("after_reset");
        check_case1_writes("after_reset", base);
    endtask

    task automatic test_wrap();
        int xb;
        logic [5:0] b;
        xb = nx;
        b = 6'(xb);
        pulse_start();
        run_stream(1'b0);
        wait_done("wrap");
        vectors++;
        if (nx - xb !== 2) begin
            errors++;
            $display("FAIL wrap_count: writes=%0d required 2", nx - xb);
        end
        vectors++;
        if ({x_addr[b], x_data[b]} !== {32'hFFFF_FFFC, 32'h0010_0513}) begin
            errors++;
            $display("FAIL wrap_w0: addr=%h data=%h required fffffffc 00100513", x_addr[b], x_data[b]);
        end
        vectors++;
        if ({x_addr[b+6'd1], x_data[b+6'd1]} !== {32'h0, 32'h0020_0593}) begin
            errors++;
            $display("FAIL wrap_w1: addr=%h data=%h required 00000000 00200593", x_addr[b+6'd1], x_data[b+6'd1]);
        end
    endtask

    task automatic test_start_ignored();
        int base;
        logic [5:0] b;
        base = nwr;
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(s1[i], 0);
        rx_valid = 1'b0;
        pulse_start();
        vectors++;
        if ({busy, done, rx_ready} !== 3'b101) begin
            errors++;
            $display("FAIL start_in_data: busy/done/rdy=%b required 101", {busy, done, rx_ready});
        end
        send_byte(s1[6], 0);
        send_byte(s1[7], 0);
        rx_valid = 1'b0;
        vectors++;
        if (MemWrite !== 1'b1) begin
            errors++;
            $display("FAIL start_in_wr_setup: MemWrite=%b required 1", MemWrite);
        end
        pulse_start();
        for (int i = 8; i < 12; i++) send_byte(s1[i], 0);
        rx_valid = 1'b0;
        wait_done("start_ignored");
        check_case1_writes("start_ignored", base);
        base = nwr;
        pulse_start();
        vectors++;
        if ({done, busy, core_hold, rx_ready} !== 4'b0111) begin
            errors++;
            $display("FAIL start_in_done: done/busy/hold/rdy=%b required 0111", {done, busy, core_hold, rx_ready});
        end
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'hEF, 0); send_byte(8'hBE, 0); send_byte(8'hAD, 0); send_byte(8'hDE, 1);
        rx_valid = 1'b0;
        wait_done("reload");
        b = 6'(base);
        vectors++;
        if ({nwr - base, wr_addr[b], wr_data[b]} !== {32'd1, 32'h0, 32'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL reload_write: count=%0d addr=%h data=%h required 1 00000000 deadbeef",
                     nwr - base, wr_addr[b], wr_data[b]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_errors();
        test_gaps();
        test_async_reset();
        test_wrap();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
